// File: rtl/sram_block_responder.sv
// rtl/sram_block_responder.sv - block-wide request responder serialising 64-word blocks onto a word-wide SRAM port
// Optional one-entry pending request slot enabled by REQ_QUEUE_EN.
module sram_block_responder #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64
) (
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        read_enable,
    input  logic                                        write_enable,
    input  logic [ADDR_SIZE_BITS-1:0]                   address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] write_data,
    output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic                                        busy,
    output logic                                        data_valid,
    output logic                                        write_done,
    output logic                                        req_error,
    output logic [ADDR_SIZE_BITS-1:0]                   mem_addr,
    output logic                                        mem_ren,
    output logic                                        mem_wen,
    output logic [WORD_SIZE_BYTES*8-1:0]                mem_wdata,
    input  logic [WORD_SIZE_BYTES*8-1:0]                mem_rdata
);

    localparam int WORD_W = WORD_SIZE_BYTES * 8;
    localparam int BLK_W  = WORD_W * DATA_SIZE_WORDS;
    localparam int CNT_W  = $clog2(DATA_SIZE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_SIZE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, RD_BURST, RD_DRAIN, RD_DONE, WR_BURST, WR_DONE} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            beat;
    logic [CNT_W-1:0]            beat_nx;
    logic [CNT_W-1:0]            beat_pv;
    logic [ADDR_SIZE_BITS-1:0]   base;
    logic [BLK_W-1:0]            wbuf;
    // Top word never lands here: it goes straight from mem_rdata into read_data during drain.
    logic [BLK_W-WORD_W-1:0]     shadow;

    logic                        req_both;
    logic                        req_legal;
    logic                        misaligned;
    logic [ADDR_SIZE_BITS-1:0]   aligned_addr;

    logic                        start_rd;
    logic                        start_wr;
    logic                        start_err;
    logic [ADDR_SIZE_BITS-1:0]   start_base;
    logic [BLK_W-1:0]            start_wdata;

`ifdef REQ_QUEUE_EN
    logic                        p_valid;
    logic                        p_write;
    logic [ADDR_SIZE_BITS-1:0]   p_base;
    logic [BLK_W-1:0]            p_wdata;
    logic                        from_pend;
    logic                        capture;
`endif

    assign req_both     = read_enable & write_enable;
    assign req_legal    = read_enable ^ write_enable;
    assign misaligned   = |address[CNT_W-1:0];
    assign aligned_addr = {address[ADDR_SIZE_BITS-1:CNT_W], {CNT_W{1'b0}}};
    assign beat_nx      = beat + CNT_W'(1);
    assign beat_pv      = beat - CNT_W'(1);

    // A burst starts from IDLE, or back-to-back from a DONE state when a request is waiting.
    always_comb begin
        start_rd    = 1'b0;
        start_wr    = 1'b0;
        start_err   = 1'b0;
        start_base  = aligned_addr;
        start_wdata = write_data;
`ifdef REQ_QUEUE_EN
        from_pend   = 1'b0;
        capture     = 1'b0;
`endif
        if (state == IDLE) begin
            start_rd  = req_legal & read_enable;
            start_wr  = req_legal & write_enable;
            start_err = req_both | (req_legal & misaligned);
        end
`ifdef REQ_QUEUE_EN
        else begin
            start_err = req_both | (req_legal & (p_valid | misaligned));
            if (state == RD_DONE || state == WR_DONE) begin
                if (p_valid) begin
                    from_pend   = 1'b1;
                    start_rd    = ~p_write;
                    start_wr    = p_write;
                    start_base  = p_base;
                    start_wdata = p_wdata;
                end else begin
                    start_rd = req_legal & read_enable;
                    start_wr = req_legal & write_enable;
                end
            end else begin
                capture = req_legal & ~p_valid;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            beat       <= '0;
            base       <= '0;
            wbuf       <= '0;
            read_data  <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            write_done <= 1'b0;
            req_error  <= 1'b0;
            mem_addr   <= '0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            data_valid <= 1'b0;
            write_done <= 1'b0;
            req_error  <= start_err;
            if (start_rd || start_wr) begin
                base     <= start_base;
                beat     <= '0;
                busy     <= 1'b1;
                mem_addr <= start_base;
                if (start_rd) begin
                    state   <= RD_BURST;
                    mem_ren <= 1'b1;
                end else begin
                    state     <= WR_BURST;
                    wbuf      <= start_wdata;
                    mem_wen   <= 1'b1;
                    mem_wdata <= start_wdata[WORD_W-1:0];
                end
            end else begin
                case (state)
                    RD_BURST: begin
                        if (beat == LAST_BEAT) begin
                            mem_ren  <= 1'b0;
                            mem_addr <= '0;
                            state    <= RD_DRAIN;
                        end else begin
                            beat     <= beat_nx;
                            mem_addr <= base | ADDR_SIZE_BITS'(beat_nx);
                        end
                    end
                    RD_DRAIN: begin
                        read_data  <= {mem_rdata, shadow};
                        data_valid <= 1'b1;
                        state      <= RD_DONE;
                    end
                    WR_BURST: begin
                        if (beat == LAST_BEAT) begin
                            mem_wen    <= 1'b0;
                            mem_addr   <= '0;
                            mem_wdata  <= '0;
                            write_done <= 1'b1;
                            state      <= WR_DONE;
                        end else begin
                            beat      <= beat_nx;
                            mem_addr  <= base | ADDR_SIZE_BITS'(beat_nx);
                            mem_wdata <= wbuf[beat_nx*WORD_W +: WORD_W];
                        end
                    end
                    RD_DONE, WR_DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read word for beat k arrives one cycle after its strobe, i.e. while beat k+1 is issued.
    always_ff @(posedge clk) begin
        if (state == RD_BURST && beat != '0) begin
            shadow[beat_pv*WORD_W +: WORD_W] <= mem_rdata;
        end
    end

`ifdef REQ_QUEUE_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            p_valid <= 1'b0;
            p_write <= 1'b0;
            p_base  <= '0;
            p_wdata <= '0;
        end else if (capture) begin
            p_valid <= 1'b1;
            p_write <= write_enable;
            p_base  <= aligned_addr;
            p_wdata <= write_data;
        end else if (from_pend) begin
            p_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sram_block_responder.sv
// tb/tb_sram_block_responder.sv - directed table-driven bench for sram_block_responder
module tb_sram_block_responder;

    localparam int AW = 24;
    localparam int WW = 24;
    localparam int NW = 64;
    localparam int BW = WW * NW;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          read_enable = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] address = '0;
    logic [BW-1:0] write_data = '0;
    logic [BW-1:0] read_data;
    logic          busy, data_valid, write_done, req_error;
    logic [AW-1:0] mem_addr;
    logic          mem_ren, mem_wen;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_block_responder dut (
        .clk(clk), .n_rst(n_rst),
        .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .write_data(write_data), .read_data(read_data),
        .busy(busy), .data_valid(data_valid), .write_done(write_done), .req_error(req_error),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [WW-1:0] mem [logic [AW-1:0]];

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : '0;
        if (mem_wen) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            chk("strobe_excl", mem_ren & mem_wen, 0);
            if (!mem_ren && !mem_wen) chk("idle_bus", {mem_addr, mem_wdata}, 0);
        end
    end

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [WW-1:0] wbase;
        int            exp_ren;
        int            exp_wen;
        int            exp_first;
        int            exp_last;
        logic [AW-1:0] exp_a0;
        int            exp_evt;
        int            exp_err;
        int            exp_busy;
        logic [WW-1:0] pat_base;
        logic [WW-1:0] pat_step;
    } vec_t;

    vec_t vecs[7];

    task automatic apply_vec(input vec_t v, input string tag);
        int first = -1, last = -1, ren = 0, wen = 0, evt = -1, npulse = 0;
        int err = -1, nerr = 0, busy_last = 0, nbusy = 0, beat = 0, seq_bad = 0, nbad = 0;
        logic [AW-1:0] a0 = '0;
        @(negedge clk);
        read_enable  = v.rd;
        write_enable = v.wr;
        address      = v.addr;
        for (int k = 0; k < NW; k++) write_data[k*WW +: WW] = v.wbase + WW'(k);
        @(posedge clk);
        #1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (mem_ren || mem_wen) begin
                if (first < 0) begin
                    first = c;
                    a0 = mem_addr;
                end
                last = c;
                if (mem_addr != a0 + AW'(beat)) seq_bad++;
                if (mem_wen && mem_wdata != v.wbase + WW'(beat)) seq_bad++;
                beat++;
            end
            if (mem_ren) ren++;
            if (mem_wen) wen++;
            if (data_valid || write_done) begin
                evt = c;
                npulse++;
            end
            if (req_error) begin
                err = c;
                nerr++;
            end
            if (busy) begin
                busy_last = c;
                nbusy++;
            end
        end
        chk({tag, "_ren_cnt"}, ren, v.exp_ren);
        chk({tag, "_wen_cnt"}, wen, v.exp_wen);
        chk({tag, "_first"}, first, v.exp_first);
        chk({tag, "_last"}, last, v.exp_last);
        chk({tag, "_addr0"}, a0, v.exp_a0);
        chk({tag, "_seq"}, seq_bad, 0);
        chk({tag, "_evt_cyc"}, evt, v.exp_evt);
        chk({tag, "_evt_cnt"}, npulse, (v.exp_evt >= 0) ? 1 : 0);
        chk({tag, "_err_cyc"}, err, v.exp_err);
        chk({tag, "_err_cnt"}, nerr, (v.exp_err >= 0) ? 1 : 0);
        chk({tag, "_busy_last"}, busy_last, v.exp_busy);
        chk({tag, "_busy_cnt"}, nbusy, v.exp_busy);
        for (int k = 0; k < NW; k++)
            if (read_data[k*WW +: WW] != v.pat_base + v.pat_step * WW'(k)) nbad++;
        chk({tag, "_rdata_bad"}, nbad, 0);
    endtask

    task automatic busy_req_test();
        int wen_first = -1, dv = -1, wd = -1, err = -1, busy_last = 0, nbusy = 0;
        logic [AW-1:0] wen_a0 = '0;
        @(negedge clk);
        read_enable = 1'b1;
        address     = 24'h000000;
        @(posedge clk);
        #1;
        read_enable = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (mem_wen && wen_first < 0) begin
                wen_first = c;
                wen_a0 = mem_addr;
            end
            if (data_valid) dv = c;
            if (write_done) wd = c;
            if (req_error) err = c;
            if (busy) begin
                busy_last = c;
                nbusy++;
            end
            read_enable  = 1'b0;
            write_enable = 1'b0;
            if (c == 10) begin
                write_enable = 1'b1;
                address      = 24'h010000;
                for (int k = 0; k < NW; k++) write_data[k*WW +: WW] = 24'h330000 + WW'(k);
            end
`ifdef REQ_QUEUE_EN
            if (c == 20) begin
                read_enable = 1'b1;
                address     = 24'h000100;
            end
`endif
        end
        chk("busyreq_dv", dv, 66);
`ifdef REQ_QUEUE_EN
        chk("busyreq_wen_first", wen_first, 67);
        chk("busyreq_wen_addr", wen_a0, 24'h010000);
        chk("busyreq_wdone", wd, 131);
        chk("busyreq_err", err, 21);
        chk("busyreq_busy_last", busy_last, 131);
        chk("busyreq_busy_cnt", nbusy, 131);
`else
        chk("busyreq_wen_first", wen_first, -1);
        chk("busyreq_wdone", wd, -1);
        chk("busyreq_err", err, -1);
        chk("busyreq_busy_last", busy_last, 66);
        chk("busyreq_busy_cnt", nbusy, 66);
`endif
    endtask

    initial begin
        int stray;
        vecs[0] = '{1'b1, 1'b0, 24'h000000, 24'h000000, 64, 0, 1, 64, 24'h000000, 66, -1, 66, 24'h000000, 24'd3};
        vecs[1] = '{1'b0, 1'b1, 24'h023000, 24'hA50000, 0, 64, 1, 64, 24'h023000, 65, -1, 65, 24'h000000, 24'd3};
        vecs[2] = '{1'b1, 1'b0, 24'h023000, 24'h000000, 64, 0, 1, 64, 24'h023000, 66, -1, 66, 24'hA50000, 24'd1};
        vecs[3] = '{1'b1, 1'b0, 24'h000047, 24'h000000, 64, 0, 1, 64, 24'h000040, 66, 1, 66, 24'h0000C0, 24'd3};
        vecs[4] = '{1'b1, 1'b1, 24'h000000, 24'h000000, 0, 0, -1, -1, 24'h000000, -1, 1, 0, 24'h0000C0, 24'd3};
        vecs[5] = '{1'b0, 1'b1, 24'hFFFFC5, 24'h5A0000, 0, 64, 1, 64, 24'hFFFFC0, 65, 1, 65, 24'h0000C0, 24'd3};
        vecs[6] = '{1'b1, 1'b0, 24'hFFFFC0, 24'h000000, 64, 0, 1, 64, 24'hFFFFC0, 66, -1, 66, 24'h5A0000, 24'd1};

        for (int n = 0; n < 128; n++) mem[AW'(n)] = WW'(n * 3);

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_strobes", {mem_ren, mem_wen}, 0);
        chk("reset_pulses", {data_valid, write_done, req_error}, 0);
        chk("reset_rdata_nz", |read_data, 0);
        n_rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                chk("v0_word5", read_data[5*WW +: WW], 24'h00000F);
                chk("v0_word63", read_data[63*WW +: WW], 24'h0000BD);
            end
        end

        // Reset at beat 30 of a read abandons the burst.
        @(negedge clk);
        read_enable = 1'b1;
        address     = 24'h000000;
        @(posedge clk);
        #1;
        read_enable = 1'b0;
        repeat (31) @(negedge clk);
        chk("rst_mid_busy_before", busy, 1);
        chk("rst_mid_addr_before", mem_addr, 24'h00001E);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_strobes", {mem_ren, mem_wen}, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_pulses", {data_valid, write_done, req_error}, 0);
        chk("rst_mid_rdata_nz", |read_data, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        stray = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (data_valid || busy || mem_ren) stray++;
        end
        chk("rst_mid_no_resume", stray, 0);
        apply_vec(vecs[0], "after_rst");

        busy_req_test();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_block_responder.md
Name: sram_block_responder

Overview:
- SRAM-side responder for the block-wide memory interface used by the layer/alpha/texture engines.
- An initiator issues a single-cycle read or write request carrying a 64-word block (24-bit words, 1536 bits).
- The responder serialises each request into a 64-beat burst on a word-wide physical SRAM port, and returns read blocks with a one-cycle valid pulse.
- It sits between the engine arbiter and the physical SRAM macro/controller.

Parameters:
ADDR_SIZE_BITS, 24, width of block and physical word addresses
WORD_SIZE_BYTES, 3, bytes per pixel word
DATA_SIZE_WORDS, 64, words per block; power of two

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
read_enable  in  1  block read request, sampled when busy=0
write_enable  in  1  block write request, sampled when busy=0
address  in  ADDR_SIZE_BITS  block base word address
write_data  in  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  block to write; word k at bits [k*24 +: 24]
read_data  out  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  last completed read block, same packing
busy  out  1  request in progress; new requests ignored
data_valid  out  1  one-cycle pulse: read_data holds a newly completed block
write_done  out  1  one-cycle pulse: write burst finished
req_error  out  1  one-cycle pulse: illegal request
mem_addr  out  ADDR_SIZE_BITS  physical word address
mem_ren  out  1  physical read strobe
mem_wen  out  1  physical write strobe
mem_wdata  out  WORD_SIZE_BYTES*8  physical write word
mem_rdata  in  WORD_SIZE_BYTES*8  physical read word, valid the cycle after mem_ren

Behaviour:
- Reset: all outputs 0; read_data cleared; state IDLE; counters 0. Reset mid-burst abandons the burst with no done/valid pulse.
- States: IDLE, RD_BURST, RD_DRAIN, RD_DONE, WR_BURST, WR_DONE.
- IDLE, acceptance:
  - read_enable=1, write_enable=0 -> latch base, go RD_BURST.
  - write_enable=1, read_enable=0 -> latch base and write_data, go WR_BURST.
  - Both high -> req_error pulse next cycle, stay IDLE.
- Alignment: base = address with low log2(DATA_SIZE_WORDS) bits forced to 0. If those bits are nonzero, the request is still serviced from the aligned base and req_error pulses with the acceptance.
- busy: 1 from the cycle after acceptance through the RD_DONE/WR_DONE cycle inclusive; 0 in IDLE. Requests while busy=1 are ignored (no queue unless optional feature).
- RD_BURST: 64 cycles, beat counter k=0..63.
  - mem_ren=1, mem_addr=base+k.
  - mem_rdata is captured one cycle later into word k of a shadow buffer.
  - After k=63 -> RD_DRAIN, which captures word 63.
- RD_DONE: shadow buffer copied to read_data; data_valid=1 for this cycle only. read_data is stable until the next read completes and is unchanged by writes.
- WR_BURST: 64 cycles; mem_wen=1, mem_addr=base+k, mem_wdata=latched word k. Then WR_DONE: write_done=1 for one cycle.
- Latency, acceptance edge = cycle 0:
  - Read: mem_ren cycles 1-64, drain 65, data_valid cycle 66.
  - Write: mem_wen cycles 1-64, write_done cycle 65.
  - Next request is accepted in cycle 67 (read) or 66 (write).
- Physical strobes are never both high. mem_addr/mem_wdata are 0 whenever both strobes are low.
- Address arithmetic is modulo 2^ADDR_SIZE_BITS. Block base 0xFFFFC0 covers 0xFFFFC0-0xFFFFFF with no carry out.

Optional Feature:
- Macro REQ_QUEUE_EN.
- Defined: a one-entry pending register (type, base, write_data).
  - A legal request arriving while busy=1 with the slot empty is captured.
  - It is started in the cycle immediately after RD_DONE/WR_DONE, without returning to IDLE; busy stays 1.
  - A request arriving while the slot is full is dropped and req_error pulses.
- Undefined: requests while busy are silently ignored and no pending logic exists.

Test Plan:
- Preload SRAM model word n = n*3 for 0x000000-0x00003F; read_enable at address 0x000000 -> mem_ren cycles 1-64, data_valid cycle 66, read_data word 5 = 0x00000F, word 63 = 0x0000BD, busy low cycle 67.
- write_enable at 0x023000 with word k = 0xA50000+k -> mem_wen 64 cycles, addresses 0x023000-0x02303F, mem_wdata 0xA50000..0xA5003F, write_done cycle 65; readback matches.
- read_enable at 0x000047 -> req_error pulse; burst addresses 0x000040-0x00007F.
- read_enable and write_enable both high -> req_error=1, no strobes, busy stays 0.
- Assert n_rst=0 at beat 30 of a read -> all outputs 0 at once, no data_valid; a new read at 0x000000 then completes normally.
- REQ_QUEUE_EN: write at 0x010000 issued at cycle 10 of a read -> read data_valid, then write burst starts next cycle, busy never drops; a third request during the read -> req_error.
